apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master_if.sv | 35 +++
 rtl/apb_master.sv | 134 +++++++++++++
 tb/tb_apb_master.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - command, response and APB signal bundle for apb_master
interface apb_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           pready, pslverr, prdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           paddr, pwdata, psel, penable, pwrite
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           pready, pslverr, prdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           paddr, pwdata, psel, penable, pwrite
  );
endinterface

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB requester with wait-state timeout
module apb_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         pclk,
  input  logic         presetn,
  apb_master_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  // Abort fires at the edge that would bring the wait count up to TIMEOUT.
  localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic        r_cmd_ready, w_cmd_ready_nxt;
  logic        r_psel, w_psel_nxt;
  logic        r_penable, w_penable_nxt;
  logic        r_pwrite, w_pwrite_nxt;
  logic [31:0] r_paddr, w_paddr_nxt;
  logic [31:0] r_pwdata, w_pwdata_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic        r_rsp_err, w_rsp_err_nxt;
  logic        r_rsp_timeout, w_rsp_timeout_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cmd_ready   <= w_cmd_ready_nxt;
      r_psel        <= w_psel_nxt;
      r_penable     <= w_penable_nxt;
      r_pwrite      <= w_pwrite_nxt;
      r_paddr       <= w_paddr_nxt;
      r_pwdata      <= w_pwdata_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cmd_ready_nxt   = r_cmd_ready;
    w_psel_nxt        = r_psel;
    w_penable_nxt     = r_penable;
    w_pwrite_nxt      = r_pwrite;
    w_paddr_nxt       = r_paddr;
    w_pwdata_nxt      = r_pwdata;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_err_nxt     = r_rsp_err;
    w_rsp_timeout_nxt = r_rsp_timeout;
    w_cnt_nxt         = r_cnt;

    case (r_state)
      S_IDLE: begin
        w_cmd_ready_nxt = 1'b1;
        if (r_cmd_ready && bus.cmd_valid) begin
          w_cmd_ready_nxt = 1'b0;
          w_paddr_nxt     = bus.cmd_addr;
          w_pwdata_nxt    = bus.cmd_wdata;
          w_pwrite_nxt    = bus.cmd_write;
          w_psel_nxt      = 1'b1;
          w_state_nxt     = S_SETUP;
        end
      end
      S_SETUP: begin
        w_penable_nxt = 1'b1;
        w_cnt_nxt     = '0;
        w_state_nxt   = S_ACCESS;
      end
      S_ACCESS: begin
        // pready is checked first so a late ready still completes normally.
        if (bus.pready) begin
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_rsp_rdata_nxt   = r_pwrite ? 32'h0 : bus.prdata;
          w_rsp_err_nxt     = bus.pslverr;
          w_rsp_timeout_nxt = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_state_nxt       = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
          if (r_cnt == LP_LAST_WAIT) begin
            w_psel_nxt        = 1'b0;
            w_penable_nxt     = 1'b0;
            w_rsp_rdata_nxt   = 32'h0;
            w_rsp_err_nxt     = 1'b1;
            w_rsp_timeout_nxt = 1'b1;
            w_rsp_valid_nxt   = 1'b1;
            w_state_nxt       = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_cmd_ready_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.psel        = r_psel;
  assign bus.penable     = r_penable;
  assign bus.pwrite      = r_pwrite;
  assign bus.paddr       = r_paddr;
  assign bus.pwdata      = r_pwdata;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - randomized self-checking bench for apb_master
module tb_apb_master;
  localparam int TIMEOUT = 16;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;
  logic prev_psel = 1'b0;
  logic [31:0] mem [logic [31:0]];

  apb_master_if u_if ();

  apb_master #(.TIMEOUT(TIMEOUT)) u_dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (u_if)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Every sample point goes through here so the inter-transfer psel gap is always watched.
  task automatic step();
    @(negedge pclk);
    if (u_if.psel && !u_if.penable) check("psel_gap", {31'b0, prev_psel}, 32'h0);
    prev_psel = u_if.psel;
  endtask

  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input int waits, input logic serr, input int hold);
    int cyc, n_psel, n_pen, lat, acc;
    logic to, rdy, exp_err;
    logic [31:0] slv_rd, exp_rd;
    to      = (waits >= TIMEOUT);
    acc     = to ? TIMEOUT : waits + 1;
    slv_rd  = mem.exists(addr) ? mem[addr] : ~addr;
    exp_rd  = (wr || to) ? 32'h0 : slv_rd;
    exp_err = to || serr;

    u_if.cmd_valid = 1'b1;
    u_if.cmd_write = wr;
    u_if.cmd_addr  = addr;
    u_if.cmd_wdata = wdata;
    cyc = 0;
    while (!u_if.cmd_ready && cyc < 20) begin step(); cyc++; end
    check("cmd_ready_idle", {31'b0, u_if.cmd_ready}, 32'h1);
    step();
    u_if.cmd_valid = 1'b0;
    u_if.cmd_write = 1'($urandom);
    u_if.cmd_addr  = $urandom;
    u_if.cmd_wdata = $urandom;

    n_psel = 0; n_pen = 0; lat = 0;
    while (!u_if.rsp_valid && lat < 300) begin
      lat++;
      if (u_if.psel) begin
        n_psel++;
        check("paddr", u_if.paddr, addr);
        check("pwrite", {31'b0, u_if.pwrite}, {31'b0, wr});
        check("pwdata", u_if.pwdata, wdata);
      end
      if (u_if.penable) begin
        n_pen++;
        check("penable_psel", {31'b0, u_if.psel}, 32'h1);
        rdy = (n_pen == waits + 1);
        u_if.pready  = rdy;
        u_if.pslverr = rdy ? serr : 1'($urandom);
        u_if.prdata  = (rdy && !wr) ? slv_rd : $urandom;
      end else begin
        u_if.pready  = 1'($urandom);
        u_if.pslverr = 1'($urandom);
        u_if.prdata  = $urandom;
      end
      step();
    end
    u_if.pready = 1'b0;
    check("latency", lat, 1 + acc);
    check("psel_cycles", n_psel, 1 + acc);
    check("penable_cycles", n_pen, acc);
    check("psel_after", {31'b0, u_if.psel}, 32'h0);
    check("rsp_rdata", u_if.rsp_rdata, exp_rd);
    check("rsp_err", {31'b0, u_if.rsp_err}, {31'b0, exp_err});
    check("rsp_timeout", {31'b0, u_if.rsp_timeout}, {31'b0, to});

    for (int i = 0; i < hold; i++) begin
      u_if.rsp_ready = 1'b0;
      u_if.cmd_valid = 1'b1;
      u_if.pready    = 1'($urandom);
      step();
      check("hold_valid", {31'b0, u_if.rsp_valid}, 32'h1);
      check("hold_rdata", u_if.rsp_rdata, exp_rd);
      check("hold_err", {29'b0, u_if.rsp_err, u_if.rsp_timeout, u_if.cmd_ready},
            {29'b0, exp_err, to, 1'b0});
      check("hold_psel", {31'b0, u_if.psel}, 32'h0);
    end
    u_if.cmd_valid = 1'b0;
    u_if.rsp_ready = 1'b1;
    step();
    u_if.rsp_ready = 1'b0;
    check("post_rsp_valid", {31'b0, u_if.rsp_valid}, 32'h0);
    check("post_cmd_ready", {31'b0, u_if.cmd_ready}, 32'h1);

    if (wr && !to && !serr) mem[addr] = wdata;
  endtask

  task automatic reset_mid_access();
    u_if.cmd_valid = 1'b1;
    u_if.cmd_write = 1'b1;
    u_if.cmd_addr  = 32'h0C;
    u_if.cmd_wdata = 32'hDEADBEEF;
    u_if.pready    = 1'b0;
    step();
    u_if.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("rst_pre_penable", {31'b0, u_if.penable}, 32'h1);
    presetn = 1'b0;
    #1;
    check("rst_psel", {31'b0, u_if.psel}, 32'h0);
    check("rst_penable", {31'b0, u_if.penable}, 32'h0);
    check("rst_rsp_valid", {31'b0, u_if.rsp_valid}, 32'h0);
    check("rst_cmd_ready", {31'b0, u_if.cmd_ready}, 32'h0);
    step();
    step();
    presetn = 1'b1;
    check("rst_rel_cmd_ready", {31'b0, u_if.cmd_ready}, 32'h0);
    step();
    check("rst_first_edge_ready", {31'b0, u_if.cmd_ready}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      check("rst_no_rsp", {30'b0, u_if.rsp_valid, u_if.psel}, 32'h0);
      step();
    end
  endtask

  initial begin
    logic [31:0] a;
    int w;
    u_if.cmd_valid = 1'b0;
    u_if.cmd_write = 1'b0;
    u_if.cmd_addr  = '0;
    u_if.cmd_wdata = '0;
    u_if.rsp_ready = 1'b0;
    u_if.pready    = 1'b0;
    u_if.pslverr   = 1'b0;
    u_if.prdata    = '0;
    step();
    step();
    check("reset_outputs", {u_if.cmd_ready, u_if.psel, u_if.penable, u_if.pwrite,
                            u_if.rsp_valid, u_if.rsp_err, u_if.rsp_timeout, 25'b0}, 32'h0);
    check("reset_paddr", u_if.paddr | u_if.pwdata | u_if.rsp_rdata, 32'h0);
    presetn = 1'b1;
    step();
    check("reset_ready_rise", {31'b0, u_if.cmd_ready}, 32'h1);

    txn(1'b1, 32'h04, 32'h20240115, 1, 1'b0, 0);
    txn(1'b1, 32'h0C, 32'h4956414E, 0, 1'b0, 0);
    txn(1'b0, 32'h0C, $urandom, 0, 1'b0, 0);
    txn(1'b0, 32'h10, $urandom, 0, 1'b1, 0);
    txn(1'b0, 32'h14, $urandom, 999, 1'b0, 0);
    txn(1'b0, 32'h0C, $urandom, TIMEOUT - 1, 1'b0, 0);
    txn(1'b0, 32'h04, $urandom, 2, 1'b0, 5);
    reset_mid_access();
    txn(1'b0, 32'h0C, $urandom, 0, 1'b0, 1);

    for (int n = 0; n < 40; n++) begin
      a = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
      case ($urandom_range(0, 7))
        0:       w = TIMEOUT - 1;
        1:       w = TIMEOUT + 3;
        default: w = $urandom_range(0, 4);
      endcase
      txn(1'($urandom), a, $urandom, w, ($urandom_range(0, 4) == 0), $urandom_range(0, 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
